fft_stage_ctrl: RTL

//  Sequencer for the 16-point radix-2 DIF FFT datapath. On a start pulse it walks all
//  4 stages x 8 butterflies. Per cycle it drives stage/counter to twiddle_addr
//  (downstream) and ping-pong RAM read addresses to the butterfly. Matching write

---
 rtl/fft_stage_ctrl_pkg.sv | 38 +++
 rtl/fft_addr_delay.sv | 31 +++
 rtl/fft_stage_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fft_stage_ctrl_pkg.sv
// Shared constants, FSM encodings and address helpers for the 16-point FFT sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fft_stage_ctrl_pkg;

   localparam int FFT_N_LOG2     = 4;
   localparam int FFT_N_BF       = 8;
   localparam int FFT_N_STAGES   = 4;
   localparam int BF_LAT_DEFAULT = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // One read/write address bundle as it travels down the butterfly delay line.
   typedef struct packed {
      logic       vld;
      logic       bank;
      logic [3:0] addr_a;
      logic [3:0] addr_b;
   } addr_pkt_t;

   // Upper butterfly address: butterfly index k with a zero spliced in at the
   // span bit, so the low (3-stage) bits of k stay put and the rest move up one.
   function automatic logic [3:0] bf_addr_a(input logic [1:0] stage, input logic [2:0] k);
      logic [3:0] low_mask;
      logic [3:0] kx;
      kx       = {1'b0, k};
      low_mask = (4'd8 >> stage) - 4'd1;
      return ((kx & ~low_mask) << 1) | (kx & low_mask);
   endfunction

   // Lower butterfly address: partner of addr_a, one span away.
   function automatic logic [3:0] bf_addr_b(input logic [1:0] stage, input logic [2:0] k);
      return bf_addr_a(stage, k) | (4'd8 >> stage);
   endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// DEPTH x WIDTH shift register carrying read addresses forward to the write side.
// Latency: exactly DEPTH cycles from i_dat to o_dat.
// Backpressure: none; shifts every cycle, async active-low clear empties the line.
//
// Ports: clk, rst_n, i_dat[WIDTH] (sampled every edge), o_dat[WIDTH] (oldest entry).
module fft_addr_delay #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_dat,
   output logic [WIDTH-1:0] o_dat
);

   logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pipe <= '0;
      end else begin
         r_pipe[0] <= i_dat;
         for (int i = 1; i < DEPTH; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign o_dat = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// Sequencer for the 16-point radix-2 DIF FFT: 4 stages x 8 butterflies per start.
// Latency: first read 1 cycle after start; done 4*(8+BF_LAT) cycles after first read.
// Backpressure: none; start is ignored while busy and on the done cycle.
//
// Ports: clk, rst_n (async active-low), start, busy, done, stage[4], counter[4],
//        rd_valid/rd_bank/rd_addr_a/rd_addr_b (read side, this cycle),
//        wr_valid/wr_bank/wr_addr_a/wr_addr_b (read side delayed BF_LAT cycles).
module fft_stage_ctrl
   import fft_stage_ctrl_pkg::*;
#(
   parameter int N_LOG2 = FFT_N_LOG2,
   parameter int BF_LAT = BF_LAT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [3:0] stage,
   output logic [3:0] counter,
   output logic       rd_valid,
   output logic       rd_bank,
   output logic [3:0] rd_addr_a,
   output logic [3:0] rd_addr_b,
   output logic       wr_valid,
   output logic       wr_bank,
   output logic [3:0] wr_addr_a,
   output logic [3:0] wr_addr_b
);

   localparam logic [2:0] LAST_K     = 3'((1 << (N_LOG2 - 1)) - 1);
   localparam logic [1:0] LAST_STAGE = 2'(N_LOG2 - 1);
   localparam logic [2:0] DRAIN_LAST = 3'(BF_LAT - 1);

   logic [1:0] r_state;
   logic [1:0] r_stage;
   logic [2:0] r_k;
   logic [2:0] r_drain_cnt;
   logic       r_busy;
   logic       r_done;
   logic       r_rd_valid;
   logic [3:0] r_rd_a;
   logic [3:0] r_rd_b;

   logic [1:0] w_stage_nxt;
   logic [2:0] w_k_nxt;
   addr_pkt_t  w_rd_pkt;
   addr_pkt_t  w_wr_pkt;

   assign w_stage_nxt = r_stage + 2'd1;
   assign w_k_nxt     = r_k + 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_stage     <= 2'd0;
         r_k         <= 3'd0;
         r_drain_cnt <= 3'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_a      <= 4'd0;
         r_rd_b      <= 4'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // r_done is high only on the done cycle; a start there is dropped.
               if (start && !r_done) begin
                  r_state    <= ST_RUN;
                  r_busy     <= 1'b1;
                  r_stage    <= 2'd0;
                  r_k        <= 3'd0;
                  r_rd_valid <= 1'b1;
                  r_rd_a     <= bf_addr_a(2'd0, 3'd0);
                  r_rd_b     <= bf_addr_b(2'd0, 3'd0);
               end
            end
            ST_RUN: begin
               if (r_k == LAST_K) begin
                  // counter stays at its last value through the drain.
                  r_state     <= ST_DRAIN;
                  r_drain_cnt <= 3'd0;
                  r_rd_valid  <= 1'b0;
                  r_rd_a      <= 4'd0;
                  r_rd_b      <= 4'd0;
               end else begin
                  r_k    <= w_k_nxt;
                  r_rd_a <= bf_addr_a(r_stage, w_k_nxt);
                  r_rd_b <= bf_addr_b(r_stage, w_k_nxt);
               end
            end
            ST_DRAIN: begin
               // BF_LAT drain cycles let the stage's last write land before the
               // next stage reads the same bank.
               if (r_drain_cnt == DRAIN_LAST) begin
                  if (r_stage == LAST_STAGE) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_stage <= 2'd0;
                     r_k     <= 3'd0;
                  end else begin
                     r_state    <= ST_RUN;
                     r_stage    <= w_stage_nxt;
                     r_k        <= 3'd0;
                     r_rd_valid <= 1'b1;
                     r_rd_a     <= bf_addr_a(w_stage_nxt, 3'd0);
                     r_rd_b     <= bf_addr_b(w_stage_nxt, 3'd0);
                  end
               end else begin
                  r_drain_cnt <= r_drain_cnt + 3'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Bank is qualified by valid so the write side idles at all-zero rather than
   // showing an inverted idle bank.
   assign w_rd_pkt = '{vld:    r_rd_valid,
                       bank:   r_rd_valid & ~r_stage[0],
                       addr_a: r_rd_a,
                       addr_b: r_rd_b};

   fft_addr_delay #(
      .DEPTH (BF_LAT),
      .WIDTH ($bits(addr_pkt_t))
   ) u_addr_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .i_dat (w_rd_pkt),
      .o_dat (w_wr_pkt)
   );

   assign busy      = r_busy;
   assign done      = r_done;
   assign stage     = {2'b00, r_stage};
   assign counter   = {1'b0, r_k};
   assign rd_valid  = r_rd_valid;
   assign rd_bank   = r_stage[0];
   assign rd_addr_a = r_rd_a;
   assign rd_addr_b = r_rd_b;
   assign wr_valid  = w_wr_pkt.vld;
   assign wr_bank   = w_wr_pkt.bank;
   assign wr_addr_a = w_wr_pkt.addr_a;
   assign wr_addr_b = w_wr_pkt.addr_b;

endmodule
